// File: rtl/instr_decode_pkg.sv
// Shared decode definitions for instr_decode_pipe: opcode and ALU-control encodings,
// the decoded-control record, and the opcode decoder.
package instr_decode_pkg;

    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_ADDI = 6'd3;
    localparam logic [5:0] OP_LW   = 6'd4;
    localparam logic [5:0] OP_SW   = 6'd5;
    localparam logic [5:0] OP_AND  = 6'd6;
    localparam logic [5:0] OP_OR   = 6'd7;
    localparam logic [5:0] OP_NOR  = 6'd8;
    localparam logic [5:0] OP_BEQ  = 6'd9;
    localparam logic [5:0] OP_BNE  = 6'd10;
    localparam logic [5:0] OP_SLT  = 6'd11;
    localparam logic [5:0] OP_EOF  = 6'd12;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_NOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;

    typedef struct packed {
        logic [3:0] alu_ctrl;
        logic       alu_src_b;
        logic       mem_wr;
        logic       wb_sel;
        logic       wb_en;
        logic       wb_to_rd;   // destination is rd (R-type) rather than rt
        logic       is_beq;
        logic       is_bne;
        logic       is_eof;
    } ctrl_t;

    // Unknown opcodes fall through to the all-zero record, i.e. a nop.
    function automatic ctrl_t decode_op(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_ADD:  begin c.wb_en = 1'b1; c.wb_to_rd = 1'b1; c.alu_ctrl = ALU_ADD; end
            OP_SUB:  begin c.wb_en = 1'b1; c.wb_to_rd = 1'b1; c.alu_ctrl = ALU_SUB; end
            OP_AND:  begin c.wb_en = 1'b1; c.wb_to_rd = 1'b1; c.alu_ctrl = ALU_AND; end
            OP_OR:   begin c.wb_en = 1'b1; c.wb_to_rd = 1'b1; c.alu_ctrl = ALU_OR;  end
            OP_NOR:  begin c.wb_en = 1'b1; c.wb_to_rd = 1'b1; c.alu_ctrl = ALU_NOR; end
            OP_SLT:  begin c.wb_en = 1'b1; c.wb_to_rd = 1'b1; c.alu_ctrl = ALU_SLT; end
            OP_ADDI: begin c.wb_en = 1'b1; c.alu_src_b = 1'b1; end
            OP_LW:   begin c.wb_en = 1'b1; c.alu_src_b = 1'b1; c.wb_sel = 1'b1; end
            OP_SW:   begin c.mem_wr = 1'b1; c.alu_src_b = 1'b1; end
            OP_BEQ:  begin c.is_beq = 1'b1; c.alu_ctrl = ALU_SUB; end
            OP_BNE:  begin c.is_bne = 1'b1; c.alu_ctrl = ALU_SUB; end
            OP_EOF:  c.is_eof = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/reg_file_param.sv
// Register file: two asynchronous read ports, one synchronous write port,
// register 0 hard-wired to zero.
module reg_file_param #(
    parameter int  XLEN = 32,
    parameter int  NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];

    always_comb begin
        // NOTE: mem_d takes the current contents first so every path assigns it; no latch.
        mem_d = mem_q;
        if (we && (wa != '0)) mem_d[wa] = wd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the array is reset because every register must read 0 straight after reset.
            for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : mem_q[ra1];
    assign rd2 = (ra2 == '0) ? '0 : mem_q[ra2];

endmodule

// File: rtl/instr_decode_pipe.sv
// Registered decode stage with busy-bit scoreboard and RUN/HALT controller.
// Define DECODE_WB_BYPASS_EN to forward same-cycle write-back data into the operands.
module instr_decode_pipe
    import instr_decode_pkg::*;
#(
    parameter int  XLEN       = 32,
    parameter int  NREG       = 32,
    parameter int  IMM_SIGNED = 0,
    localparam int AW         = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rd1,
    output logic [XLEN-1:0] out_rd2,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_br_target,
    output logic [3:0]      out_alu_ctrl,
    output logic            out_alu_src_b,
    output logic            out_mem_wr,
    output logic            out_wb_sel,
    output logic            out_wb_en,
    output logic            out_br_taken,
    output logic [AW-1:0]   out_wb_addr,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic            halted
);

    typedef enum logic {ST_RUN, ST_HALT} state_e;

    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] br_target;
        logic [3:0]      alu_ctrl;
        logic            alu_src_b;
        logic            mem_wr;
        logic            wb_sel;
        logic            wb_en;
        logic            br_taken;
        logic [AW-1:0]   wb_addr;
    } out_t;

    state_e          state_q, state_d;
    out_t            out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic [NREG-1:0] busy_q, busy_d;

    ctrl_t           ctrl;
    logic [AW-1:0]   rs_a, rt_a, rd_a, wb_addr_dec;
    logic [XLEN-1:0] rf_rd1, rf_rd2, rd1_val, rd2_val, imm_ext;
    logic            hit_rs, hit_rt, stall, accept, br_taken;

    assign ctrl = decode_op(in_instr[31:26]);
    assign rs_a = AW'(in_instr[25:21]);
    assign rt_a = AW'(in_instr[20:16]);
    assign rd_a = AW'(in_instr[15:11]);

    reg_file_param #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs_a),
        .ra2   (rt_a),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2),
        .we    (wr_en),
        .wa    (wr_addr),
        .wd    (wr_data)
    );

    assign hit_rs = wr_en && (wr_addr == rs_a) && (rs_a != '0);
    assign hit_rt = wr_en && (wr_addr == rt_a) && (rt_a != '0);

`ifdef DECODE_WB_BYPASS_EN
    assign rd1_val = hit_rs ? wr_data : rf_rd1;
    assign rd2_val = hit_rt ? wr_data : rf_rd2;
    assign stall   = (busy_q[rs_a] && !hit_rs) || (busy_q[rt_a] && !hit_rt);
`else
    // Without forwarding a register written this cycle is only readable next cycle.
    assign rd1_val = rf_rd1;
    assign rd2_val = rf_rd2;
    assign stall   = busy_q[rs_a] || busy_q[rt_a] || hit_rs || hit_rt;
`endif

    assign imm_ext = (IMM_SIGNED != 0) ? {{(XLEN-16){in_instr[15]}}, in_instr[15:0]}
                                       : {{(XLEN-16){1'b0}}, in_instr[15:0]};
    assign wb_addr_dec = !ctrl.wb_en ? '0 : (ctrl.wb_to_rd ? rd_a : rt_a);
    assign br_taken    = (ctrl.is_beq && (rd1_val == rd2_val)) ||
                         (ctrl.is_bne && (rd1_val != rd2_val));

    assign in_ready = (state_q == ST_RUN) && !stall && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = out_valid_q && !out_ready;
        busy_d      = busy_q;
        if (wr_en) busy_d[wr_addr] = 1'b0;
        if (accept) begin
            out_valid_d         = 1'b1;
            out_d.rd1           = rd1_val;
            out_d.rd2           = rd2_val;
            out_d.imm           = imm_ext;
            out_d.br_target     = in_pc + imm_ext;
            out_d.alu_ctrl      = ctrl.alu_ctrl;
            out_d.alu_src_b     = ctrl.alu_src_b;
            out_d.mem_wr        = ctrl.mem_wr;
            out_d.wb_sel        = ctrl.wb_sel;
            out_d.wb_en         = ctrl.wb_en;
            out_d.br_taken      = br_taken;
            out_d.wb_addr       = wb_addr_dec;
            // Set after the clear so a same-edge set and clear leaves the bit set.
            if (ctrl.wb_en && (wb_addr_dec != '0)) busy_d[wb_addr_dec] = 1'b1;
            if (ctrl.is_eof) state_d = ST_HALT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= '0;
        end else begin
            // NOTE: non-blocking so every state element samples pre-edge values together.
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_rd1       = out_q.rd1;
    assign out_rd2       = out_q.rd2;
    assign out_imm       = out_q.imm;
    assign out_br_target = out_q.br_target;
    assign out_alu_ctrl  = out_q.alu_ctrl;
    assign out_alu_src_b = out_q.alu_src_b;
    assign out_mem_wr    = out_q.mem_wr;
    assign out_wb_sel    = out_q.wb_sel;
    assign out_wb_en     = out_q.wb_en;
    assign out_br_taken  = out_q.br_taken;
    assign out_wb_addr   = out_q.wb_addr;
    assign halted        = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Self-checking bench for instr_decode_pipe: directed scenarios plus a randomized run
// checked against an instruction-level reference model.
module tb_instr_decode_pipe;

    logic        clk;
    logic        reset, in_valid, out_ready, wr_en;
    logic [31:0] in_instr, in_pc, wr_data;
    logic [4:0]  wr_addr;

    logic        in_ready, out_valid, out_alu_src_b, out_mem_wr, out_wb_sel, out_wb_en, out_br_taken, halted;
    logic [31:0] out_rd1, out_rd2, out_imm, out_br_target;
    logic [3:0]  out_alu_ctrl;
    logic [4:0]  out_wb_addr;

    logic        s_in_ready, s_out_valid, s_alu_src_b, s_mem_wr, s_wb_sel, s_wb_en, s_br_taken, s_halted;
    logic [31:0] s_rd1, s_rd2, s_out_imm, s_br_target;
    logic [3:0]  s_alu_ctrl;
    logic [4:0]  s_wb_addr;

    int n_checks = 0;
    int n_pass   = 0;

    instr_decode_pipe #(.XLEN(32), .NREG(32), .IMM_SIGNED(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .out_rd1(out_rd1),
        .out_rd2(out_rd2), .out_imm(out_imm), .out_br_target(out_br_target),
        .out_alu_ctrl(out_alu_ctrl), .out_alu_src_b(out_alu_src_b), .out_mem_wr(out_mem_wr),
        .out_wb_sel(out_wb_sel), .out_wb_en(out_wb_en), .out_br_taken(out_br_taken),
        .out_wb_addr(out_wb_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .halted(halted)
    );

    // Sign-extending twin driven by the same stimulus.
    instr_decode_pipe #(.XLEN(32), .NREG(32), .IMM_SIGNED(1)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .out_valid(s_out_valid), .out_ready(out_ready), .out_rd1(s_rd1),
        .out_rd2(s_rd2), .out_imm(s_out_imm), .out_br_target(s_br_target),
        .out_alu_ctrl(s_alu_ctrl), .out_alu_src_b(s_alu_src_b), .out_mem_wr(s_mem_wr),
        .out_wb_sel(s_wb_sel), .out_wb_en(s_wb_en), .out_br_taken(s_br_taken),
        .out_wb_addr(s_wb_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .halted(s_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [31:0] rd1, rd2, imm, tgt;
        logic [3:0]  alu;
        logic        src_b, mem_wr, wb_sel, wb_en, br, chk_alu, is_br;
        logic [4:0]  wb_addr;
    } exp_t;

    // Expected decode of one instruction from the instruction-set rules (zero-extended imm).
    function automatic exp_t model_decode(input logic [31:0] instr, input logic [31:0] pc,
                                          input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        int   op;
        logic is_r;
        op        = int'(instr[31:26]);
        e         = '0;
        e.rd1     = r1;
        e.rd2     = r2;
        e.imm     = {16'h0, instr[15:0]};
        e.tgt     = pc + e.imm;
        is_r      = op inside {1, 2, 6, 7, 8, 11};
        e.wb_en   = is_r || op == 3 || op == 4;
        e.wb_addr = is_r ? instr[15:11] : instr[20:16];
        e.wb_sel  = (op == 4);
        e.mem_wr  = (op == 5);
        e.src_b   = op inside {3, 4, 5};
        e.chk_alu = is_r || op inside {3, 4, 5, 12};
        case (op)
            2:       e.alu = 4'd1;
            6:       e.alu = 4'd2;
            7:       e.alu = 4'd3;
            8:       e.alu = 4'd4;
            11:      e.alu = 4'd5;
            default: e.alu = 4'd0;
        endcase
        e.br    = (op == 9 && r1 == r2) || (op == 10 && r1 != r2);
        e.is_br = op inside {9, 10};
        return e;
    endfunction

    function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; wr_en = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if ({out_valid, halted} !== 2'b00) $display("FAIL reset_flags: valid/halted=%b expected 00", {out_valid, halted});
        else n_pass++;
        n_checks++;
        if ({out_rd1, out_rd2, out_imm, out_br_target, out_alu_ctrl, out_alu_src_b, out_mem_wr,
             out_wb_sel, out_wb_en, out_br_taken, out_wb_addr} !== '0)
            $display("FAIL reset_outputs: rd1=%h imm=%h wb_en=%b expected all zero", out_rd1, out_imm, out_wb_en);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_ready: in_ready=%b expected 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_add();
        do_reset();
        wr_reg(5'd1, 32'd5);
        wr_reg(5'd2, 32'd7);
        in_valid = 1'b1; in_pc = 32'h0; in_instr = mk_r(6'd1, 5'd1, 5'd2, 5'd3);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL add_ready: in_ready=%b expected 1", in_ready);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_rd1, out_rd2} !== {1'b1, 32'd5, 32'd7})
            $display("FAIL add_operands: valid=%b rd1=%0d rd2=%0d expected 1 5 7", out_valid, out_rd1, out_rd2);
        else n_pass++;
        n_checks++;
        if ({out_alu_ctrl, out_wb_addr, out_wb_en, out_alu_src_b} !== {4'd0, 5'd3, 1'b1, 1'b0})
            $display("FAIL add_ctrl: alu=%0d wb_addr=%0d wb_en=%b src_b=%b expected 0 3 1 0",
                     out_alu_ctrl, out_wb_addr, out_wb_en, out_alu_src_b);
        else n_pass++;
    endtask

    task automatic test_imm();
        do_reset();
        in_valid = 1'b1; in_instr = mk_i(6'd3, 5'd0, 5'd1, 16'hFFFF);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (out_imm !== 32'h0000FFFF) $display("FAIL imm_zero_ext: got %h expected 0000ffff", out_imm);
        else n_pass++;
        n_checks++;
        if (s_out_imm !== 32'hFFFFFFFF) $display("FAIL imm_sign_ext: got %h expected ffffffff", s_out_imm);
        else n_pass++;
        n_checks++;
        if ({out_alu_src_b, out_wb_addr, out_wb_sel} !== {1'b1, 5'd1, 1'b0})
            $display("FAIL addi_ctrl: src_b=%b wb_addr=%0d wb_sel=%b expected 1 1 0", out_alu_src_b, out_wb_addr, out_wb_sel);
        else n_pass++;
    endtask

    task automatic test_hazard();
        logic exp_rdy;
        do_reset();
        wr_reg(5'd1, 32'd3);
        out_ready = 1'b1; in_valid = 1'b1; in_instr = mk_i(6'd4, 5'd1, 5'd4, 16'd0);
        @(negedge clk);
        in_instr = mk_r(6'd1, 5'd4, 5'd1, 5'd5);
        #1;
        n_checks++;
        if ({out_valid, out_wb_sel, out_wb_addr} !== {1'b1, 1'b1, 5'd4})
            $display("FAIL lw_ctrl: valid=%b wb_sel=%b wb_addr=%0d expected 1 1 4", out_valid, out_wb_sel, out_wb_addr);
        else n_pass++;
        repeat (3) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL hazard_stall: in_ready=%b expected 0", in_ready);
            else n_pass++;
            @(negedge clk);
        end
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'd42;
`ifdef DECODE_WB_BYPASS_EN
        exp_rdy = 1'b1;
`else
        exp_rdy = 1'b0;
`endif
        #1;
        n_checks++;
        if (in_ready !== exp_rdy) $display("FAIL hazard_wb_cycle: in_ready=%b expected %b", in_ready, exp_rdy);
        else n_pass++;
        @(negedge clk);
        wr_en = 1'b0;
        if (!exp_rdy) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b1) $display("FAIL hazard_release: in_ready=%b expected 1", in_ready);
            else n_pass++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_rd1, out_rd2, out_wb_addr} !== {1'b1, 32'd42, 32'd3, 5'd5})
            $display("FAIL hazard_issue: valid=%b rd1=%0d rd2=%0d wb_addr=%0d expected 1 42 3 5",
                     out_valid, out_rd1, out_rd2, out_wb_addr);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        wr_reg(5'd1, 32'd11);
        out_ready = 1'b0; in_valid = 1'b1; in_instr = mk_r(6'd1, 5'd1, 5'd0, 5'd2);
        @(negedge clk);
        in_instr = mk_i(6'd3, 5'd0, 5'd6, 16'h0055);
        repeat (3) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL bp_ready: in_ready=%b expected 0", in_ready);
            else n_pass++;
            n_checks++;
            if ({out_valid, out_rd1, out_wb_addr, out_wb_en} !== {1'b1, 32'd11, 5'd2, 1'b1})
                $display("FAIL bp_hold: valid=%b rd1=%0d wb_addr=%0d expected 1 11 2", out_valid, out_rd1, out_wb_addr);
            else n_pass++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL bp_resume: in_ready=%b expected 1", in_ready);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_imm, out_wb_addr, out_rd1} !== {1'b1, 32'h55, 5'd6, 32'd0})
            $display("FAIL bp_next: valid=%b imm=%h wb_addr=%0d rd1=%0d expected 1 55 6 0",
                     out_valid, out_imm, out_wb_addr, out_rd1);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL bp_drain: out_valid=%b expected 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_branch();
        do_reset();
        wr_reg(5'd1, 32'd9);
        wr_reg(5'd2, 32'd9);
        in_valid = 1'b1; in_pc = 32'h10; in_instr = mk_i(6'd9, 5'd1, 5'd2, 16'd4);
        @(negedge clk);
        in_instr = mk_i(6'd10, 5'd1, 5'd2, 16'd4);
        #1;
        n_checks++;
        if ({out_br_taken, out_br_target, out_wb_en} !== {1'b1, 32'h14, 1'b0})
            $display("FAIL beq: taken=%b target=%h wb_en=%b expected 1 14 0", out_br_taken, out_br_target, out_wb_en);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_br_taken, out_br_target} !== {1'b1, 1'b0, 32'h14})
            $display("FAIL bne: valid=%b taken=%b target=%h expected 1 0 14", out_valid, out_br_taken, out_br_target);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] mregs [32];
        logic        mbusy [32];
        int          pend [$];
        logic [5:0]  ops [14] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                                  6'd8, 6'd9, 6'd10, 6'd11, 6'd13, 6'd63};
        exp_t        exp_q, nxt;
        logic        exp_v, exp_rdy, acc, mstall;
        logic [4:0]  rs, rt;
        logic [31:0] v1, v2;
        do_reset();
        exp_v = 1'b0; exp_q = '0; nxt = '0;
        for (int i = 0; i < 32; i++) begin mregs[i] = '0; mbusy[i] = 1'b0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = {ops[$urandom_range(0, 13)], 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), 16'($urandom)};
            in_pc     = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            wr_en     = 1'b0; wr_addr = 5'd0;
            wr_data   = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
                wr_en = 1'b1; wr_addr = 5'(pend.pop_front());
            end
            #1;
            n_checks++;
            if (out_valid !== exp_v) $display("FAIL rand_valid cyc %0d: got %b expected %b", cyc, out_valid, exp_v);
            else n_pass++;
            if (exp_v) begin
                n_checks++;
                if ({out_rd1, out_rd2, out_imm} !== {exp_q.rd1, exp_q.rd2, exp_q.imm})
                    $display("FAIL rand_data cyc %0d: rd1=%h rd2=%h imm=%h expected %h %h %h", cyc,
                             out_rd1, out_rd2, out_imm, exp_q.rd1, exp_q.rd2, exp_q.imm);
                else n_pass++;
                n_checks++;
                if ({out_wb_en, out_mem_wr, out_wb_sel, out_br_taken} !== {exp_q.wb_en, exp_q.mem_wr, exp_q.wb_sel, exp_q.br})
                    $display("FAIL rand_ctrl cyc %0d: wb_en/mem_wr/wb_sel/br=%b expected %b", cyc,
                             {out_wb_en, out_mem_wr, out_wb_sel, out_br_taken},
                             {exp_q.wb_en, exp_q.mem_wr, exp_q.wb_sel, exp_q.br});
                else n_pass++;
                if (exp_q.chk_alu) begin
                    n_checks++;
                    if ({out_alu_ctrl, out_alu_src_b} !== {exp_q.alu, exp_q.src_b})
                        $display("FAIL rand_alu cyc %0d: alu=%0d src_b=%b expected %0d %b", cyc,
                                 out_alu_ctrl, out_alu_src_b, exp_q.alu, exp_q.src_b);
                    else n_pass++;
                end
                if (exp_q.wb_en) begin
                    n_checks++;
                    if (out_wb_addr !== exp_q.wb_addr)
                        $display("FAIL rand_wb_addr cyc %0d: got %0d expected %0d", cyc, out_wb_addr, exp_q.wb_addr);
                    else n_pass++;
                end
                if (exp_q.is_br) begin
                    n_checks++;
                    if (out_br_target !== exp_q.tgt)
                        $display("FAIL rand_target cyc %0d: got %h expected %h", cyc, out_br_target, exp_q.tgt);
                    else n_pass++;
                end
            end
            rs = in_instr[25:21];
            rt = in_instr[20:16];
`ifdef DECODE_WB_BYPASS_EN
            mstall = (mbusy[rs] && !(wr_en && wr_addr == rs)) || (mbusy[rt] && !(wr_en && wr_addr == rt));
            v1 = (wr_en && wr_addr == rs && rs != 0) ? wr_data : mregs[rs];
            v2 = (wr_en && wr_addr == rt && rt != 0) ? wr_data : mregs[rt];
`else
            mstall = mbusy[rs] || mbusy[rt] || (wr_en && wr_addr != 0 && (wr_addr == rs || wr_addr == rt));
            v1 = mregs[rs];
            v2 = mregs[rt];
`endif
            exp_rdy = !mstall && (!exp_v || out_ready);
            n_checks++;
            if (in_ready !== exp_rdy) $display("FAIL rand_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_rdy);
            else n_pass++;
            acc = in_valid && exp_rdy;
            if (acc) begin
                nxt = model_decode(in_instr, in_pc, v1, v2);
                exp_v = 1'b1; exp_q = nxt;
            end else if (out_ready) begin
                exp_v = 1'b0;
            end
            if (wr_en) begin
                if (wr_addr != 0) mregs[wr_addr] = wr_data;
                mbusy[wr_addr] = 1'b0;
            end
            if (acc && nxt.wb_en && nxt.wb_addr != 0) begin
                mbusy[nxt.wb_addr] = 1'b1;
                pend.push_back(int'(nxt.wb_addr));
            end
            @(negedge clk);
        end
        in_valid = 1'b0; wr_en = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_halt();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = mk_i(6'd12, 5'd3, 5'd4, 16'hFFFF);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL eof_ready: in_ready=%b expected 1", in_ready);
        else n_pass++;
        @(negedge clk);
        in_instr = mk_r(6'd1, 5'd1, 5'd2, 5'd3);
        #1;
        n_checks++;
        if ({out_valid, out_alu_ctrl, out_alu_src_b, out_mem_wr, out_wb_sel, out_wb_en, out_br_taken} !== {1'b1, 9'd0})
            $display("FAIL eof_ctrl: valid=%b alu=%0d wb_en=%b mem_wr=%b expected valid 1, controls 0",
                     out_valid, out_alu_ctrl, out_wb_en, out_mem_wr);
        else n_pass++;
        repeat (3) begin
            n_checks++;
            if ({halted, in_ready, out_valid} !== 3'b101)
                $display("FAIL halt_hold: halted/in_ready/out_valid=%b expected 101", {halted, in_ready, out_valid});
            else n_pass++;
            @(negedge clk);
            #1;
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({halted, out_valid} !== 2'b00)
            $display("FAIL halt_async_reset: halted/out_valid=%b expected 00", {halted, out_valid});
        else n_pass++;
        n_checks++;
        if ({out_rd1, out_imm, out_wb_addr, out_wb_en} !== '0)
            $display("FAIL reset_discard: rd1=%h imm=%h expected zero", out_rd1, out_imm);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL halt_exit: in_ready=%b expected 1", in_ready);
        else n_pass++;
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        test_reset();
        test_add();
        test_imm();
        test_hazard();
        test_backpressure();
        test_branch();
        test_random();
        test_halt();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_decode_pipe.md
INSTR_DECODE_PIPE -- requirements
Module: instr_decode_pipe

Interface
REQ-001 Parameter XLEN, default 32: datapath width of register data, PC and immediate.
REQ-002 Parameter NREG, default 32: register count, power of two, 2..32; AW = log2(NREG).
REQ-003 Parameter IMM_SIGNED, default 0: 1 = sign-extend instr[15:0], 0 = zero-extend.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 in_valid / in_ready  in/out  1/1  fetch-side handshake.
REQ-007 in_instr / in_pc  in  32/XLEN  instruction word (opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0]) and its PC.
REQ-008 out_valid / out_ready  out/in  1/1  execute-side handshake.
REQ-009 out_rd1, out_rd2, out_imm, out_br_target  out  XLEN  operands, extended immediate, branch target.
REQ-010 out_alu_ctrl  out  4  add=0, sub=1, and=2, or=3, nor=4, slt=5.
REQ-011 out_alu_src_b, out_mem_wr, out_wb_sel, out_wb_en, out_br_taken  out  1 each  control bits; out_wb_addr  out  AW.
REQ-012 wr_en, wr_addr[AW-1:0], wr_data[XLEN-1:0]  in  write-back port.
REQ-013 halted  out  1  high after eof has been accepted.

Function
REQ-014 Opcodes: add 1, sub 2, addi 3, lw 4, sw 5, and 6, or 7, nor 8, beq 9, bne 10, slt 11, eof 12; any other opcode, including all-zero words, decodes as a nop: wb_en=0, mem_wr=0, br_taken=0.
REQ-015 R-type ops (add/sub/and/or/nor/slt): wb_en=1, wb_addr=rd, alu_src_b=0. addi/lw: wb_en=1, wb_addr=rt, alu_src_b=1, alu_ctrl=0; lw additionally sets wb_sel=1. sw: mem_wr=1, wb_en=0, alu_src_b=1, alu_ctrl=0.
REQ-016 beq/bne: br_taken = (rd1==rd2) or (rd1!=rd2) respectively; br_target = in_pc + out_imm modulo 2^XLEN; wb_en=0.
REQ-017 Output is a registered pipeline stage, latency 1: an instruction accepted on edge N appears on out_* after edge N.
REQ-018 Accept condition: in_valid & in_ready; in_ready = !halted & !stall & (!out_valid | out_ready).
REQ-019 out_* remain stable while out_valid & !out_ready; out_valid drops after the handshake unless a new instruction is accepted on the same edge.
REQ-020 Scoreboard: one busy bit per register; set on accepting an instruction with wb_en=1 for wb_addr != 0; cleared when wr_en writes that address.
REQ-021 stall = busy[rs] or busy[rt] for the instruction at in_instr; a same-edge set and clear of one register leaves it set.
REQ-022 Register 0 reads as zero; writes to it are ignored.
REQ-023 Controller states RUN and HALT: RUN -> HALT on acceptance of eof; HALT exits only on reset; eof produces out_valid with every control bit 0.

Reset
REQ-024 On reset assertion: out_valid=0, every out_* =0, halted=0, state RUN, all busy bits 0, all registers 0, effective immediately, no clock required.
REQ-025 An instruction held in the output stage when reset asserts is discarded.

Configuration
REQ-026 DECODE_WB_BYPASS_EN defined: when wr_en writes the register being read, wr_data is forwarded to the operand, and the clearing busy bit does not stall that read.
REQ-027 DECODE_WB_BYPASS_EN undefined: operands come from register state only; a read of a register being written that cycle stalls one cycle.

Structure
REQ-028 Package instr_decode_pkg: opcode constants, ALU control constants, decoded-control typedef.
REQ-029 Sub-module reg_file_param (XLEN, NREG): two asynchronous read ports, one synchronous write port, asynchronous reset.

Verification
REQ-030 add r3,r1,r2 with r1=5, r2=7 -> after 1 cycle out_valid=1, rd1=5, rd2=7, alu_ctrl=0, wb_addr=3, wb_en=1.
REQ-031 addi with imm=0xFFFF, IMM_SIGNED=1 -> out_imm=0xFFFFFFFF; with IMM_SIGNED=0 -> 0x0000FFFF.
REQ-032 lw r4 then add r5,r4,r1 -> in_ready low until wr_en writes r4; add then issues with the written value.
REQ-033 out_ready low for 3 cycles with a valid output -> out_* unchanged, in_ready=0, no instruction lost.
REQ-034 beq with r1=r2=9, pc=0x10, imm=4 -> br_taken=1, br_target=0x14; bne with the same inputs -> br_taken=0.
REQ-035 eof accepted, then further in_valid -> halted=1, in_ready=0; reset asserted -> halted=0, out_valid=0 immediately.
